// File: rtl/finger_pkg.sv
// Shared types and constants for the finger scan controller.
package finger_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StScan,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned NUM_FINGERS = 5;
  localparam int unsigned THUMB       = 0;
  localparam int unsigned INDEX       = 1;
  localparam int unsigned MIDDLE      = 2;
  localparam int unsigned RING        = 3;
  localparam int unsigned PINKY       = 4;

  localparam int unsigned BAND_MUL    = 13;
  localparam int unsigned BAND_SHIFT  = 6;

  // Offset of band edge k from the palm left column: (w*k*13)>>6.
  function automatic logic [8:0] band_off(logic [8:0] w, logic [2:0] k);
    logic [15:0] p;
    p = 16'(w) * 16'(k) * 16'(BAND_MUL);
    return p[BAND_SHIFT +: 9];
  endfunction

endpackage

// File: rtl/finger_scan_ctrl_if.sv
// Palm box, frame-memory read port and finger results of the scan controller.
interface finger_scan_ctrl_if;
  logic       start;
  logic [7:0] palm_width;
  logic [7:0] start_of_palm_r;
  logic [7:0] start_of_palm_c;
  logic [7:0] end_of_palm_r;
  logic [7:0] end_of_palm_c;
  logic       mem_rd_en;
  logic [7:0] mem_rd_row;
  logic [7:0] mem_rd_col;
  logic       mem_rd_data;
  logic       busy;
  logic       done;
  logic       thumb_status;
  logic       index_status;
  logic       middle_status;
  logic       ring_status;
  logic       pinky_status;
  logic [2:0] finger_count;

  modport master (
    output start, palm_width, start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c,
    output mem_rd_data,
    input  mem_rd_en, mem_rd_row, mem_rd_col, busy, done,
    input  thumb_status, index_status, middle_status, ring_status, pinky_status, finger_count
  );

  modport slave (
    input  start, palm_width, start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c,
    input  mem_rd_data,
    output mem_rd_en, mem_rd_row, mem_rd_col, busy, done,
    output thumb_status, index_status, middle_status, ring_status, pinky_status, finger_count
  );
endinterface

// File: rtl/finger_run_detector.sv
// Finds runs of skin pixels in the scan row and maps qualifying runs to finger bands.
module finger_run_detector
  import finger_pkg::*;
#(
  parameter int unsigned MIN_RUN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   pix_vld_i,
  input  logic                   pix_i,
  input  logic [7:0]             pix_col_i,
  input  logic                   close_i,
  input  logic [7:0]             start_c_i,
  input  logic [3:0][8:0]        band_off_i,
  output logic [NUM_FINGERS-1:0] status_o,
  output logic [2:0]             count_o
);

  logic                   in_run_q, in_run_d;
  logic [7:0]             run_start_q, run_start_d;
  logic [7:0]             last_one_q, last_one_d;
  logic [NUM_FINGERS-1:0] status_q, status_d;
  logic [2:0]             count_q, count_d;

  logic                   hit, eff_open, close_now;
  logic [7:0]             eff_start, eff_last;
  logic [8:0]             len, center;
  logic [3:0][8:0]        band_edge;
  logic [NUM_FINGERS-1:0] band_oh;

  always_comb begin
    hit       = pix_vld_i && pix_i;
    eff_open  = in_run_q || hit;
    eff_start = (hit && !in_run_q) ? pix_col_i : run_start_q;
    eff_last  = hit ? pix_col_i : last_one_q;
    // A zero closes an open run; the drain strobe closes one that may include this pixel.
    close_now = (pix_vld_i && !pix_i && in_run_q) || (close_i && eff_open);
    len       = {1'b0, eff_last} - {1'b0, eff_start} + 9'd1;
    center    = {1'b0, eff_start} + {1'b0, len[8:1]};

    for (int k = 0; k < 4; k++) begin
      band_edge[k] = {1'b0, start_c_i} + band_off_i[k];
    end
    band_oh = '0;
    if      (center < band_edge[0]) band_oh[THUMB]  = 1'b1;
    else if (center < band_edge[1]) band_oh[INDEX]  = 1'b1;
    else if (center < band_edge[2]) band_oh[MIDDLE] = 1'b1;
    else if (center < band_edge[3]) band_oh[RING]   = 1'b1;
    else                            band_oh[PINKY]  = 1'b1;

    in_run_d    = in_run_q;
    run_start_d = run_start_q;
    last_one_d  = last_one_q;
    status_d    = status_q;
    count_d     = count_q;

    if (hit) begin
      in_run_d    = 1'b1;
      run_start_d = eff_start;
      last_one_d  = pix_col_i;
    end
    if (close_now) begin
      in_run_d = 1'b0;
      if (len >= 9'(MIN_RUN)) begin
        status_d = status_q | band_oh;
        if (count_q < 3'(NUM_FINGERS)) count_d = count_q + 3'd1;
      end
    end
    if (clear_i) begin
      in_run_d = 1'b0;
      status_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_run_q    <= 1'b0;
      run_start_q <= '0;
      last_one_q  <= '0;
      status_q    <= '0;
      count_q     <= '0;
    end else begin
      in_run_q    <= in_run_d;
      run_start_q <= run_start_d;
      last_one_q  <= last_one_d;
      status_q    <= status_d;
      count_q     <= count_d;
    end
  end

  assign status_o = status_q;
  assign count_o  = count_q;

endmodule

// File: rtl/finger_scan_ctrl.sv
// Walks one row above the palm through frame memory and reports which fingers are raised.
module finger_scan_ctrl
  import finger_pkg::*;
#(
  parameter int unsigned SCAN_OFFSET = 8,
  parameter int unsigned MIN_RUN     = 2
) (
  input  logic               clk,
  input  logic               rst,
  finger_scan_ctrl_if.slave  bus
);

  state_e          state_q, state_d;
  logic [7:0]      pw_q, pw_d, sr_q, sr_d, sc_q, sc_d, er_q, er_d, ec_q, ec_d;
  logic [7:0]      row_q, row_d, col_q, col_d;
  logic [3:0][8:0] off_q, off_d;
  logic            pix_vld_q;
  logic [7:0]      pix_col_q;
  logic [8:0]      w;
  logic [NUM_FINGERS-1:0] status;
  logic [2:0]      count;

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    sr_d    = sr_q;
    sc_d    = sc_q;
    er_d    = er_q;
    ec_d    = ec_q;
    row_d   = row_q;
    col_d   = col_q;
    off_d   = off_q;
    w       = {1'b0, ec_q} - {1'b0, sc_q} + 9'd1;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          pw_d    = bus.palm_width;
          sr_d    = bus.start_of_palm_r;
          sc_d    = bus.start_of_palm_c;
          er_d    = bus.end_of_palm_r;
          ec_d    = bus.end_of_palm_c;
          state_d = StSetup;
        end
      end
      StSetup: begin
        row_d = (sr_q < 8'(SCAN_OFFSET)) ? 8'd0 : sr_q - 8'(SCAN_OFFSET);
        col_d = sc_q;
        for (int k = 0; k < 4; k++) off_d[k] = band_off(w, 3'(k + 1));
        state_d = (pw_q == 8'd0 || ec_q < sc_q) ? StDone : StScan;
      end
      StScan: begin
        col_d = col_q + 8'd1;
        if (col_q == ec_q) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pw_q      <= '0;
      sr_q      <= '0;
      sc_q      <= '0;
      er_q      <= '0;
      ec_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      off_q     <= '0;
      pix_vld_q <= 1'b0;
      pix_col_q <= '0;
    end else begin
      state_q   <= state_d;
      pw_q      <= pw_d;
      sr_q      <= sr_d;
      sc_q      <= sc_d;
      er_q      <= er_d;
      ec_q      <= ec_d;
      row_q     <= row_d;
      col_q     <= col_d;
      off_q     <= off_d;
      // Memory answers one cycle after the strobe, so the sample tracks the issued column.
      pix_vld_q <= (state_q == StScan);
      pix_col_q <= col_q;
    end
  end

  // The bottom row is kept with the box but plays no part in the scan.
  logic unused_end_r;
  assign unused_end_r = ^er_q;

  finger_run_detector #(
    .MIN_RUN (MIN_RUN)
  ) u_det (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == StSetup),
    .pix_vld_i  (pix_vld_q),
    .pix_i      (bus.mem_rd_data),
    .pix_col_i  (pix_col_q),
    .close_i    (state_q == StDrain),
    .start_c_i  (sc_q),
    .band_off_i (off_q),
    .status_o   (status),
    .count_o    (count)
  );

  assign bus.mem_rd_en     = (state_q == StScan);
  assign bus.mem_rd_row    = row_q;
  assign bus.mem_rd_col    = col_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
  assign bus.thumb_status  = status[THUMB];
  assign bus.index_status  = status[INDEX];
  assign bus.middle_status = status[MIDDLE];
  assign bus.ring_status   = status[RING];
  assign bus.pinky_status  = status[PINKY];
  assign bus.finger_count  = count;

endmodule

// File: tb/tb_finger_scan_ctrl.sv
// Directed bench for finger_scan_ctrl with a one-row skin-pixel memory model.
module tb_finger_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  finger_scan_ctrl_if bus ();

  finger_scan_ctrl #(
    .SCAN_OFFSET (8),
    .MIN_RUN     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [255:0] skin;
  logic [4:0]   st;
  assign st = {bus.pinky_status, bus.ring_status, bus.middle_status, bus.index_status,
               bus.thumb_status};

  // Reads outside the strobe return 1 so any unwanted sampling shows up as a finger.
  always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? skin[bus.mem_rd_col] : 1'b1;

  int checks = 0;
  int passes = 0;

  int rd_cnt, rd_first, rd_last, done_cnt, done_cyc;
  bit row_ok, col_ok;
  logic [4:0] st_done, st_after;
  logic [2:0] cnt_done;
  logic busy_done, busy_after;

  task automatic drive_box(input logic [7:0] pw, sr, sc, er, ec);
    bus.palm_width      = pw;
    bus.start_of_palm_r = sr;
    bus.start_of_palm_c = sc;
    bus.end_of_palm_r   = er;
    bus.end_of_palm_c   = ec;
  endtask

  task automatic run_scan(input logic [7:0] pw, sr, sc, er, ec, input logic [7:0] exp_row,
                          input bit repulse);
    int exp_col;
    int post;
    rd_cnt = 0; rd_first = -1; rd_last = -1; done_cnt = 0; done_cyc = -1;
    row_ok = 1; col_ok = 1; post = -1; exp_col = sc;
    st_done = 'x; st_after = 'x; cnt_done = 'x; busy_done = 'x; busy_after = 'x;
    @(negedge clk);
    drive_box(pw, sr, sc, er, ec);
    bus.start = 1'b1;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        if (rd_first < 0) rd_first = c;
        rd_last = c;
        rd_cnt++;
        if (bus.mem_rd_row !== exp_row) row_ok = 0;
        if (bus.mem_rd_col !== 8'(exp_col)) col_ok = 0;
        exp_col++;
      end
      if (done_cyc > 0 && c == done_cyc + 1) begin
        busy_after = bus.busy;
        st_after   = st;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc  = c;
        st_done   = st;
        cnt_done  = bus.finger_count;
        busy_done = bus.busy;
        post      = c + 4;
      end
      // Later box changes must not disturb the latched scan.
      drive_box(8'd0, 8'd200, 8'd5, 8'd0, 8'd250);
      bus.start = repulse && c >= 3 && c <= 20;
      if (post > 0 && c >= post) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    drive_box(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    skin = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_rd_en !== 1'b0) $display("FAIL rst_rd_en got %b want 0", bus.mem_rd_en); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done got %b want 0", bus.done); else passes++;
    checks++; if (st !== 5'b0) $display("FAIL rst_status got %b want 00000", st); else passes++;
    checks++; if (bus.finger_count !== 3'd0) $display("FAIL rst_count got %0d want 0", bus.finger_count); else passes++;
    checks++; if ({bus.mem_rd_row, bus.mem_rd_col} !== 16'h0) $display("FAIL rst_addr got %h want 0000", {bus.mem_rd_row, bus.mem_rd_col}); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_two_fingers;
    skin = '0;
    skin[45:42] = 4'hf;
    skin[61:58] = 4'hf;
    run_scan(8'd40, 8'd60, 8'd40, 8'd100, 8'd79, 8'd52, 1'b0);
    checks++; if (rd_first !== 2) $display("FAIL t1_rd_first got %0d want 2", rd_first); else passes++;
    checks++; if (rd_last !== 41) $display("FAIL t1_rd_last got %0d want 41", rd_last); else passes++;
    checks++; if (rd_cnt !== 40) $display("FAIL t1_rd_cnt got %0d want 40", rd_cnt); else passes++;
    checks++; if (row_ok !== 1'b1) $display("FAIL t1_row got bad row want 52"); else passes++;
    checks++; if (col_ok !== 1'b1) $display("FAIL t1_col got bad sequence want 40..79"); else passes++;
    checks++; if (done_cyc !== 43) $display("FAIL t1_done_cyc got %0d want 43", done_cyc); else passes++;
    checks++; if (busy_done !== 1'b1) $display("FAIL t1_busy_at_done got %b want 1", busy_done); else passes++;
    checks++; if (st_done !== 5'b00101) $display("FAIL t1_status got %b want 00101", st_done); else passes++;
    checks++; if (cnt_done !== 3'd2) $display("FAIL t1_count got %0d want 2", cnt_done); else passes++;
    checks++; if (busy_after !== 1'b0) $display("FAIL t1_busy_after got %b want 0", busy_after); else passes++;
    checks++; if (st_after !== 5'b00101) $display("FAIL t1_status_hold got %b want 00101", st_after); else passes++;
  endtask

  task automatic test_short_and_edge_run;
    skin = '0;
    skin[50] = 1'b1;
    skin[79:76] = 4'hf;
    run_scan(8'd40, 8'd60, 8'd40, 8'd100, 8'd79, 8'd52, 1'b0);
    checks++; if (st_done !== 5'b10000) $display("FAIL t2_status got %b want 10000", st_done); else passes++;
    checks++; if (cnt_done !== 3'd1) $display("FAIL t2_count got %0d want 1", cnt_done); else passes++;
    checks++; if (done_cyc !== 43) $display("FAIL t2_done_cyc got %0d want 43", done_cyc); else passes++;
  endtask

  task automatic test_row_saturate;
    skin = '0;
    skin[14:12] = 3'b111;
    run_scan(8'd10, 8'd3, 8'd10, 8'd20, 8'd19, 8'd0, 1'b0);
    checks++; if (row_ok !== 1'b1) $display("FAIL t3_row got nonzero row want 0"); else passes++;
    checks++; if (rd_cnt !== 10) $display("FAIL t3_rd_cnt got %0d want 10", rd_cnt); else passes++;
    checks++; if (done_cyc !== 13) $display("FAIL t3_done_cyc got %0d want 13", done_cyc); else passes++;
    checks++; if (st_done !== 5'b00010) $display("FAIL t3_status got %b want 00010", st_done); else passes++;
  endtask

  task automatic test_no_palm;
    skin = '1;
    run_scan(8'd0, 8'd60, 8'd40, 8'd100, 8'd79, 8'd52, 1'b0);
    checks++; if (rd_cnt !== 0) $display("FAIL t4_rd_cnt got %0d want 0", rd_cnt); else passes++;
    checks++; if (done_cyc !== 2) $display("FAIL t4_done_cyc got %0d want 2", done_cyc); else passes++;
    checks++; if (st_done !== 5'b0) $display("FAIL t4_status got %b want 00000", st_done); else passes++;
    checks++; if (cnt_done !== 3'd0) $display("FAIL t4_count got %0d want 0", cnt_done); else passes++;
    run_scan(8'd5, 8'd60, 8'd50, 8'd100, 8'd40, 8'd52, 1'b0);
    checks++; if (rd_cnt !== 0) $display("FAIL t4b_rd_cnt got %0d want 0", rd_cnt); else passes++;
    checks++; if (done_cyc !== 2) $display("FAIL t4b_done_cyc got %0d want 2", done_cyc); else passes++;
  endtask

  task automatic test_reset_mid_scan;
    skin = '0;
    skin[45:42] = 4'hf;
    skin[61:58] = 4'hf;
    @(negedge clk);
    drive_box(8'd40, 8'd60, 8'd40, 8'd100, 8'd79);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.mem_rd_en !== 1'b0) $display("FAIL t5_rd_en got %b want 0", bus.mem_rd_en); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL t5_busy got %b want 0", bus.busy); else passes++;
    checks++; if (st !== 5'b0) $display("FAIL t5_status got %b want 00000", st); else passes++;
    checks++; if (bus.finger_count !== 3'd0) $display("FAIL t5_count got %0d want 0", bus.finger_count); else passes++;
    @(negedge clk);
    rst = 1'b0;
    run_scan(8'd40, 8'd60, 8'd40, 8'd100, 8'd79, 8'd52, 1'b0);
    checks++; if (done_cyc !== 43) $display("FAIL t5_done_cyc got %0d want 43", done_cyc); else passes++;
    checks++; if (st_done !== 5'b00101) $display("FAIL t5_status_after got %b want 00101", st_done); else passes++;
    checks++; if (cnt_done !== 3'd2) $display("FAIL t5_count_after got %0d want 2", cnt_done); else passes++;
  endtask

  task automatic test_back_to_back;
    skin = '0;
    for (int i = 0; i < 7; i++) begin
      skin[8 * i + 2] = 1'b1;
      skin[8 * i + 3] = 1'b1;
    end
    run_scan(8'd64, 8'd30, 8'd0, 8'd90, 8'd63, 8'd22, 1'b1);
    checks++; if (rd_cnt !== 64) $display("FAIL t6_rd_cnt got %0d want 64", rd_cnt); else passes++;
    checks++; if (col_ok !== 1'b1) $display("FAIL t6_col got bad sequence want 0..63"); else passes++;
    checks++; if (done_cyc !== 67) $display("FAIL t6_done_cyc got %0d want 67", done_cyc); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL t6_done_cnt got %0d want 1", done_cnt); else passes++;
    checks++; if (cnt_done !== 3'd5) $display("FAIL t6_count got %0d want 5", cnt_done); else passes++;
    checks++; if (st_done !== 5'b01111) $display("FAIL t6_status got %b want 01111", st_done); else passes++;
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_two_fingers();
    test_short_and_edge_run();
    test_row_saturate();
    test_no_palm();
    test_reset_mid_scan();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
